// File: rtl/demux6_buf_pkg.sv
// Shared constants for the 1-to-6 registered demultiplexer.
package demux6_buf_pkg;

  localparam int unsigned SEL_W      = 3;
  localparam int unsigned NUM_CH     = 6;
  localparam int unsigned DROP_CNT_W = 8;

  localparam logic [SEL_W-1:0] CH0 = 3'b000;
  localparam logic [SEL_W-1:0] CH1 = 3'b001;
  localparam logic [SEL_W-1:0] CH2 = 3'b010;
  localparam logic [SEL_W-1:0] CH3 = 3'b011;
  localparam logic [SEL_W-1:0] CH4 = 3'b100;
  localparam logic [SEL_W-1:0] CH5 = 3'b101;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux6_slot.sv
// One-entry valid/ready holding register for a single demux channel.
module demux6_slot
  import demux6_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_e state_q;
  slot_state_e state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A write always wins: a simultaneous drain and write keeps the slot full.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SLOT_EMPTY: if (wr)        state_d = SLOT_FULL;
      SLOT_FULL:  if (rd && !wr) state_d = SLOT_EMPTY;
      default:                   state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (wr) begin
      data <= wdata;
    end
  end

  assign valid = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux6_buf.sv
// Registered 1-to-6 demux with per-channel holding slots.
// Optional illegal-select drop counter enabled by DEMUX6_DROP_CNT_EN.
module demux6_buf
  import demux6_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [WIDTH-1:0]  y0,
  output logic [WIDTH-1:0]  y1,
  output logic [WIDTH-1:0]  y2,
  output logic [WIDTH-1:0]  y3,
  output logic [WIDTH-1:0]  y4,
  output logic [WIDTH-1:0]  y5,
  output logic              sel_err
`ifdef DEMUX6_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  logic              sel_legal;
  logic              illegal_hs;
  logic [NUM_CH-1:0] wr;
  logic [WIDTH-1:0]  y_arr [NUM_CH];

  assign sel_legal  = (in_sel < SEL_W'(NUM_CH));
  assign illegal_hs = in_valid && !sel_legal;

  // Illegal selects are always accepted and discarded.
  always_comb begin
    in_ready = 1'b1;
    wr       = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (in_sel == SEL_W'(k)) begin
        in_ready = !out_valid[k] || out_ready[k];
      end
    end
    for (int k = 0; k < int'(NUM_CH); k++) begin
      wr[k] = in_valid && in_ready && (in_sel == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_slot
    demux6_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[k]),
      .wdata (in_data),
      .rd    (out_ready[k]),
      .valid (out_valid[k]),
      .data  (y_arr[k])
    );
  end

  assign y0 = y_arr[CH0];
  assign y1 = y_arr[CH1];
  assign y2 = y_arr[CH2];
  assign y3 = y_arr[CH3];
  assign y4 = y_arr[CH4];
  assign y5 = y_arr[CH5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= illegal_hs;
    end
  end

`ifdef DEMUX6_DROP_CNT_EN
  // Saturating count of discarded beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (illegal_hs && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux6_buf.sv
// Directed self-checking bench for demux6_buf.
module tb_demux6_buf;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_sel;
  logic [5:0]       out_valid;
  logic [5:0]       out_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3, y4, y5;
  logic             sel_err;
`ifdef DEMUX6_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  demux6_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y4        (y4),
    .y5        (y5),
    .sel_err   (sel_err)
`ifdef DEMUX6_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; leave 1 ns so outputs are settled and away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_data   = 8'h00;
    out_ready = 6'b000000;
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_y2", 32'(y2), 32'h0);
    check_eq("rst_sel_err", 32'(sel_err), 32'h0);
`ifdef DEMUX6_DROP_CNT_EN
    check_eq("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
    rst_n = 1'b1;
    step();

    // Single beat to channel 2.
    drive(1'b1, 3'd2, 8'hA5);
    check_eq("ch2_in_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 3'd0, 8'h00);
    check_eq("ch2_out_valid", 32'(out_valid), 32'h04);
    check_eq("ch2_y2", 32'(y2), 32'hA5);
    out_ready = 6'b111111;
    step();
    check_eq("ch2_drained", 32'(out_valid), 32'h0);
    check_eq("ch2_y2_hold", 32'(y2), 32'hA5);
    out_ready = 6'b000000;

    // Backpressure on channel 3, then same-cycle drain and refill.
    drive(1'b1, 3'd3, 8'h5A);
    step();
    drive(1'b1, 3'd3, 8'h77);
    check_eq("ch3_full_in_ready", 32'(in_ready), 32'h0);
    step();
    check_eq("ch3_y3_unchanged", 32'(y3), 32'h5A);
    check_eq("ch3_out_valid", 32'(out_valid), 32'h08);
    out_ready = 6'b001000;
    drive(1'b1, 3'd3, 8'h3C);
    check_eq("ch3_drain_in_ready", 32'(in_ready), 32'h1);
    step();
    out_ready = 6'b000000;
    drive(1'b0, 3'd0, 8'h00);
    check_eq("ch3_still_valid", 32'(out_valid[3]), 32'h1);
    check_eq("ch3_y3_new", 32'(y3), 32'h3C);

    // Stalled channel 0 does not block channels 1 and 5.
    drive(1'b1, 3'd0, 8'h99);
    step();
    drive(1'b1, 3'd1, 8'h11);
    check_eq("ch1_in_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b1, 3'd5, 8'h22);
    check_eq("ch5_in_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 3'd0, 8'h00);
    check_eq("indep_y1", 32'(y1), 32'h11);
    check_eq("indep_y5", 32'(y5), 32'h22);
    check_eq("indep_out_valid", 32'(out_valid), 32'h2B);
    out_ready = 6'b111111;
    step();
    out_ready = 6'b000000;
    check_eq("indep_drained", 32'(out_valid), 32'h0);

    // Illegal select is consumed and flagged.
    drive(1'b1, 3'd7, 8'hFF);
    check_eq("ill_in_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 3'd0, 8'h00);
    check_eq("ill_sel_err", 32'(sel_err), 32'h1);
    check_eq("ill_out_valid", 32'(out_valid), 32'h0);
`ifdef DEMUX6_DROP_CNT_EN
    check_eq("ill_drop_cnt1", 32'(drop_cnt), 32'h1);
`endif
    step();
    check_eq("ill_sel_err_low", 32'(sel_err), 32'h0);
    drive(1'b1, 3'd6, 8'h12);
    step();
    check_eq("ill_b2b_1", 32'(sel_err), 32'h1);
    step();
    check_eq("ill_b2b_2", 32'(sel_err), 32'h1);
    drive(1'b0, 3'd0, 8'h00);
    step();
    check_eq("ill_b2b_end", 32'(sel_err), 32'h0);
`ifdef DEMUX6_DROP_CNT_EN
    check_eq("ill_drop_cnt3", 32'(drop_cnt), 32'h3);
    drive(1'b1, 3'd7, 8'hFF);
    for (int i = 0; i < 297; i++) step();
    drive(1'b0, 3'd0, 8'h00);
    check_eq("ill_drop_sat", 32'(drop_cnt), 32'hFF);
`endif
    check_eq("ill_no_slot", 32'(out_valid), 32'h0);

    // Full-rate stream into channel 4.
    out_ready = 6'b010000;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 3'd4, 8'(i));
      step();
      check_eq($sformatf("stream_y4_%0d", i), 32'(y4), 32'(i));
      check_eq($sformatf("stream_v4_%0d", i), 32'(out_valid), 32'h10);
    end
    drive(1'b0, 3'd0, 8'h00);
    step();
    check_eq("stream_drained", 32'(out_valid), 32'h0);
    out_ready = 6'b000000;

    // Asynchronous reset clears buffered beats without an edge.
    drive(1'b1, 3'd0, 8'hC0);
    step();
    drive(1'b1, 3'd5, 8'hC5);
    step();
    drive(1'b0, 3'd0, 8'h00);
    check_eq("pre_rst_valid", 32'(out_valid), 32'h21);
    check_eq("pre_rst_y0", 32'(y0), 32'hC0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(out_valid), 32'h0);
    check_eq("async_rst_y0", 32'(y0), 32'h0);
    check_eq("async_rst_y5", 32'(y5), 32'h0);
    #3;
    rst_n = 1'b1;
    step();
    check_eq("post_rst_valid", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
